// File: rtl/hazard_stall_unit.sv
// ID-stage interlock for the 5-stage pipeline: tracks in-flight destinations and
// holds, bubbles or flushes the front end for hazards the bypass cannot cover.
module hazard_stall_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter bit FWD_EN       = 1'b1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  ex_br_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  hazard_busy,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] rd;
  } dst_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  // The WB slot is not stored: the register file writes in the first half-cycle,
  // so an instruction past MEM can never stall ID.
  dst_t             r_ex_dst;
  logic             r_ex_memread;
  dst_t             r_mem_dst;
  state_t           r_state;
  logic [1:0]       r_flush_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_ex_hit;
  logic       w_mem_hit;
  logic       w_raw;
  logic       w_br;
  logic       w_in_flush;
  logic       w_dh;
  logic       w_dh_stall;
  logic [1:0] w_flush_dec;
  dst_t       w_id_dst;

  function automatic logic f_match(input dst_t e, input logic [REG_ADDR_W-1:0] src,
                                   input logic use_src);
    return e.valid && e.regwrite && (e.rd != '0) && (e.rd == src) && use_src;
  endfunction

  assign w_ex_hit  = f_match(r_ex_dst, id_rs1, id_use_rs1) ||
                     f_match(r_ex_dst, id_rs2, id_use_rs2);
  assign w_mem_hit = f_match(r_mem_dst, id_rs1, id_use_rs1) ||
                     f_match(r_mem_dst, id_rs2, id_use_rs2);

  // With a bypass only a load still in EX is too late to forward.
  assign w_raw       = FWD_EN ? (w_ex_hit && r_ex_memread) : (w_ex_hit || w_mem_hit);
  assign w_br        = ex_br_taken && !rst;
  assign w_in_flush  = (r_state == S_FLUSH) && !rst;
  assign w_dh        = id_valid && !ex_br_taken && !rst && w_raw;
  assign w_dh_stall  = w_dh && !w_in_flush;
  assign w_flush_dec = r_flush_cnt - 2'd1;
  assign w_id_dst    = '{valid: id_valid && !idex_bubble, regwrite: id_regwrite, rd: id_rd};

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (w_br || w_in_flush) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_dh) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      // NOTE: only the valid bits matter, but whole entries are cleared so nothing stale survives reset.
      r_ex_dst     <= '0;
      r_ex_memread <= 1'b0;
      r_mem_dst    <= '0;
    end else begin
      r_mem_dst    <= r_ex_dst;
      r_ex_dst     <= w_id_dst;
      r_ex_memread <= id_memread;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_flush_cnt <= 2'd0;
    end else begin
      case (r_state)
        S_RUN, S_STALL: begin
          if (ex_br_taken) begin
            if (FLUSH_CYCLES > 1) begin
              r_state     <= S_FLUSH;
              r_flush_cnt <= FLUSH_LOAD;
            end else begin
              r_state <= S_RUN;
            end
          end else if (w_dh) begin
            r_state <= S_STALL;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_FLUSH: begin
          if (ex_br_taken) begin
            r_flush_cnt <= FLUSH_LOAD;
          end else begin
            r_flush_cnt <= w_flush_dec;
            if (w_flush_dec == 2'd0) r_state <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_dh_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign hazard_busy = (r_state != S_RUN);
  assign stall_count = r_stall_cnt;

endmodule
